// File: rtl/serial_nibble_rx.sv
// serial_nibble_rx: rebuilds WIDTH-bit words from a framed, LSB-first serial
// stream (start=0, WIDTH data bits, optional even parity, stop=1).
// Optional feature macro: SERIAL_NIBBLE_RX_PARITY_EN adds the parity bit/state.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ser_in     serial data bit, meaningful only when ser_valid=1
//   ser_valid  bit enable for ser_in
//   data_out   last correctly received word (held until next good frame)
//   data_valid one-cycle strobe when data_out updates
//   frame_err  one-cycle strobe when a frame is rejected
//   busy       high while a frame is in progress
module serial_nibble_rx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_STOP   = 2'd3
    } state_t;
`endif

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_sh, w_sh_nxt;
    logic [WIDTH-1:0]   r_data, w_data_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_err, w_err_nxt;
    logic               r_busy, w_busy_nxt;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    logic               r_par_err, w_par_err_nxt;
`endif
    logic               w_frame_ok;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sh      <= w_sh_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            r_par_err <= w_par_err_nxt;
`endif
        end
    end

    // Stop-bit verdict: good stop bit and, when compiled in, no parity mismatch
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    assign w_frame_ok = ser_in & ~r_par_err;
`else
    assign w_frame_ok = ser_in;
`endif

    // Next-state and next-output logic; everything holds while ser_valid=0
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sh_nxt      = r_sh;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        w_par_err_nxt = r_par_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (ser_valid && !ser_in) begin
                    w_state_nxt   = S_DATA;
                    w_cnt_nxt     = '0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                    w_par_err_nxt = 1'b0;
`endif
                end
            end
            S_DATA: begin
                if (ser_valid) begin
                    w_sh_nxt  = {ser_in, r_sh[WIDTH-1:1]};
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            S_PARITY: begin
                if (ser_valid) begin
                    // Even parity: received bit must equal XOR of the payload
                    w_par_err_nxt = ser_in ^ (^r_sh);
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (ser_valid) begin
                    if (w_frame_ok) begin
                        w_data_nxt  = r_sh;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Testbench for serial_nibble_rx: directed frames, a queue-based frame model
// checked every cycle, plus hand-computed literal expectations.
module tb_serial_nibble_rx;

    localparam int unsigned W = 4;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    localparam int unsigned FLEN = W + 3;
`else
    localparam int unsigned FLEN = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ser_in;
    logic         ser_valid;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         frame_err;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_dv     = 0;
    int n_err    = 0;
    logic [W-1:0] got_q[$];

    serial_nibble_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: collect valid link bits of the current frame, judge it when complete
    bit           q[$];
    logic [W-1:0] m_data;
    logic         m_valid, m_err, m_busy;
    logic [W-1:0] m_word;
    logic         m_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_data  <= '0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_busy  <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            if (ser_valid && !(q.size() == 0 && ser_in)) q.push_back(ser_in);
            if (q.size() == FLEN) begin
                m_word = '0;
                for (int i = 0; i < W; i++) m_word[i] = q[1 + i];
                m_ok = q[FLEN - 1];
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
                if (q[W + 1] != (^m_word)) m_ok = 1'b0;
`endif
                if (m_ok) begin
                    m_data  <= m_word;
                    m_valid <= 1'b1;
                end else begin
                    m_err   <= 1'b1;
                end
                q.delete();
            end
            m_busy <= (q.size() != 0);
        end
    end

    // Compare process: every cycle on the falling edge
    always @(negedge clk) begin
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("data_valid", 32'(data_valid), 32'(m_valid));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_busy));
        if (data_valid && frame_err) chk("pulse_exclusive", 32'(1), 32'(0));
        if (data_valid) begin
            n_dv++;
            got_q.push_back(data_out);
        end
        if (frame_err) n_err++;
    end

    task automatic send_bit(input logic b, input int gap);
        @(posedge clk); #1;
        ser_in    = b;
        ser_valid = 1'b1;
        repeat (gap) begin
            @(posedge clk); #1;
            ser_valid = 1'b0;
            ser_in    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic stop, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) send_bit(w[i], gap);
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        send_bit(^w, gap);
`endif
        send_bit(stop, gap);
    endtask

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    task automatic send_frame_par(input logic [W-1:0] w, input logic pbit);
        send_bit(1'b0, 0);
        for (int i = 0; i < W; i++) send_bit(w[i], 0);
        send_bit(pbit, 0);
        send_bit(1'b1, 0);
    endtask
`endif

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ser_valid = 1'b0;
            ser_in    = 1'b1;
        end
    endtask

    initial begin
        int dv0;
        int er0;
        rst_n     = 1'b0;
        ser_in    = 1'b1;
        ser_valid = 1'b0;
        #22;
        chk("reset_data_out", 32'(data_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Line idle: ones with ser_valid=1 must not start a frame
        repeat (10) begin
            @(posedge clk); #1;
            ser_in    = 1'b1;
            ser_valid = 1'b1;
        end
        idle(1);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_data_out", 32'(data_out), 32'h0);
        chk("idle_pulses", 32'(n_dv + n_err), 32'h0);

        // 4'b1001: pulse visible right after the edge sampling the stop bit
        send_frame(4'b1001, 1'b1, 0);
        idle(1);
        chk("f9_valid_now", 32'(data_valid), 32'h1);
        chk("f9_data", 32'(data_out), 32'h9);
        idle(1);
        chk("f9_valid_one_cycle", 32'(data_valid), 32'h0);
        chk("f9_busy_low", 32'(busy), 32'h0);

        // Same frame with 3 idle cycles between valid bits
        dv0 = n_dv;
        send_frame(4'b1001, 1'b1, 3);
        idle(2);
        chk("gap_dv_count", 32'(n_dv - dv0), 32'h1);
        chk("gap_data", 32'(data_out), 32'h9);

        // Back-to-back frames, no idle bit in between
        dv0 = n_dv;
        send_frame(4'b0101, 1'b1, 0);
        send_frame(4'b1001, 1'b1, 0);
        idle(2);
        chk("b2b_dv_count", 32'(n_dv - dv0), 32'h2);
        chk("b2b_first", 32'(got_q[got_q.size() - 2]), 32'h5);
        chk("b2b_second", 32'(got_q[got_q.size() - 1]), 32'h9);

        // Bad stop bit: error, data kept, next frame fine
        dv0 = n_dv;
        er0 = n_err;
        send_frame(4'b0110, 1'b0, 0);
        idle(1);
        chk("bad_stop_err", 32'(frame_err), 32'h1);
        chk("bad_stop_no_dv", 32'(data_valid), 32'h0);
        chk("bad_stop_hold", 32'(data_out), 32'h9);
        send_frame(4'b0011, 1'b1, 0);
        idle(2);
        chk("after_err_data", 32'(data_out), 32'h3);
        chk("after_err_counts", 32'((n_dv - dv0) * 16 + (n_err - er0)), 32'h11);

        // Reset in mid-frame clears outputs at once
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        @(posedge clk); #1;
        ser_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(data_out), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        #10;
        rst_n = 1'b1;
        // Ones after release must not complete the discarded frame
        dv0 = n_dv;
        er0 = n_err;
        repeat (6) send_bit(1'b1, 0);
        idle(2);
        chk("post_rst_quiet", 32'((n_dv - dv0) + (n_err - er0)), 32'h0);
        send_frame(4'b1010, 1'b1, 0);
        idle(2);
        chk("post_rst_frame", 32'(data_out), 32'hA);

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        send_frame_par(4'b1001, 1'b0);
        idle(1);
        chk("par_ok_valid", 32'(data_valid), 32'h1);
        chk("par_ok_data", 32'(data_out), 32'h9);
        send_frame_par(4'b1001, 1'b1);
        idle(1);
        chk("par_bad_err", 32'(frame_err), 32'h1);
        chk("par_bad_no_dv", 32'(data_valid), 32'h0);
        idle(1);
`endif

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
